// File: rtl/hilo_seq_unit_pkg.sv
// rtl/hilo_seq_unit_pkg.sv - ALU op codes and multiply/divide sequencer state type
package hilo_seq_unit_pkg;

  localparam logic [3:0] ALU_MULT  = 4'h8;
  localparam logic [3:0] ALU_MULTU = 4'h9;
  localparam logic [3:0] ALU_DIV   = 4'hA;
  localparam logic [3:0] ALU_DIVU  = 4'hB;
  localparam logic [3:0] ALU_MTHI  = 4'hC;
  localparam logic [3:0] ALU_MTLO  = 4'hD;

  typedef enum logic [1:0] {
    MDU_IDLE,
    MDU_MUL,
    MDU_DIV,
    MDU_FIX
  } mdu_state_t;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == ALU_MULT) || (op == ALU_MULTU) || (op == ALU_DIV) || (op == ALU_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == ALU_DIV) || (op == ALU_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [3:0] op);
    return (op == ALU_MULT) || (op == ALU_DIV);
  endfunction

endpackage

// File: rtl/hilo_seq_unit_if.sv
// rtl/hilo_seq_unit_if.sv - request/result bundle between execute stage and HI/LO sequencer
interface hilo_seq_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       control;
  logic [WIDTH-1:0] numberA;
  logic [WIDTH-1:0] numberB;
  logic             busy;
  logic             done;
  logic             divZero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, control, numberA, numberB,
    input  busy, done, divZero, hi, lo
  );

  modport slave (
    input  start, control, numberA, numberB,
    output busy, done, divZero, hi, lo
  );
endinterface

// File: rtl/hilo_seq_unit_div_step.sv
// rtl/hilo_seq_unit_div_step.sv - one combinational restoring-division step
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] remainder,
  input  logic [WIDTH-1:0] quotient,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quot_next
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             fits;

  // Extra top bit catches the borrow since shifted can exceed WIDTH bits.
  assign shifted   = {remainder, quotient[WIDTH-1]};
  assign diff      = {1'b0, shifted} - {2'b00, divisor};
  assign fits      = ~diff[WIDTH+1];
  assign rem_next  = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quot_next = {quotient[WIDTH-2:0], fits};

endmodule

// File: rtl/hilo_seq_unit.sv
// rtl/hilo_seq_unit.sv - multi-cycle MULT/DIV sequencer owning the HI/LO registers
module hilo_seq_unit
  import hilo_seq_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic           clock,
  input logic           reset,
  hilo_seq_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mdu_state_t         state;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic               neg_res;
  logic               neg_rem;
  logic               op_div;
  logic               div_zero;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               busy_q;
  logic               done_q;
  logic               dz_q;

  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   quot_next;
  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0]   quot_fixed;
  logic [WIDTH-1:0]   rem_fixed;

  assign sign_a = is_signed_op(bus.control) & bus.numberA[WIDTH-1];
  assign sign_b = is_signed_op(bus.control) & bus.numberB[WIDTH-1];
  assign a_abs  = sign_a ? (~bus.numberA + 1'b1) : bus.numberA;
  assign b_abs  = sign_b ? (~bus.numberB + 1'b1) : bus.numberB;

  // acc holds {partial product, remaining multiplier} for MUL and
  // {partial remainder, dividend/quotient} for DIV.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .remainder (acc[2*WIDTH-1:WIDTH]),
    .quotient  (acc[WIDTH-1:0]),
    .divisor   (mcand),
    .rem_next  (rem_next),
    .quot_next (quot_next)
  );

  assign prod_fixed = neg_res ? (~acc + 1'b1) : acc;
  assign quot_fixed = neg_res ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
  assign rem_fixed  = neg_rem ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= MDU_IDLE;
      count    <= '0;
      mcand    <= '0;
      acc      <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      op_div   <= 1'b0;
      div_zero <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      case (state)
        MDU_IDLE: begin
          if (bus.start) begin
            if (is_muldiv(bus.control)) begin
              state    <= is_div_op(bus.control) ? MDU_DIV : MDU_MUL;
              count    <= '0;
              busy_q   <= 1'b1;
              mcand    <= b_abs;
              acc      <= {{WIDTH{1'b0}}, a_abs};
              neg_res  <= sign_a ^ sign_b;
              neg_rem  <= sign_a;
              op_div   <= is_div_op(bus.control);
              div_zero <= (bus.numberB == '0);
            end else if (bus.control == ALU_MTHI) begin
              hi_q <= bus.numberA;
            end else if (bus.control == ALU_MTLO) begin
              lo_q <= bus.numberA;
            end
          end
        end
        MDU_MUL: begin
          acc   <= mul_next;
          count <= count + 1'b1;
          if (count == LAST) state <= MDU_FIX;
        end
        MDU_DIV: begin
          acc   <= {rem_next, quot_next};
          count <= count + 1'b1;
          if (count == LAST) state <= MDU_FIX;
        end
        MDU_FIX: begin
          if (op_div) begin
            // A zero divisor leaves |A| as remainder, so the sign fix restores numberA.
            lo_q <= div_zero ? {WIDTH{1'b1}} : quot_fixed;
            hi_q <= rem_fixed;
          end else begin
            {hi_q, lo_q} <= prod_fixed;
          end
          state  <= MDU_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          dz_q   <= op_div & div_zero;
        end
        default: state <= MDU_IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.divZero = dz_q;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;

endmodule
